// File: rtl/vx_dvg_arb_pkg.sv
// Shared divergence-op types: split/join payloads and the buffered request record.
package vx_dvg_arb_pkg;

  localparam int NUM_WARPS      = 8;
  localparam int NW_WIDTH       = 3;
  localparam int NUM_THREADS    = 4;
  localparam int DV_STACK_SIZEW = 2;

  typedef struct packed {
    logic                   valid;
    logic                   is_dvg;
    logic [NUM_THREADS-1:0] then_tmask;
    logic [NUM_THREADS-1:0] else_tmask;
    logic [31:0]            next_pc;
  } split_t;

  typedef struct packed {
    logic                      valid;
    logic [DV_STACK_SIZEW-1:0] stack_ptr;
  } join_t;

  typedef struct packed {
    logic [NW_WIDTH-1:0] wid;
    logic                is_join;
    split_t              split;
    join_t               sjoin;
  } dvg_req_t;

  // Index width that stays at least one bit for a single requester.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_dvg_arb_rr.sv
// Round-robin arbiter: one grant per cycle, priority moves past the winner.
module vx_rr_arbiter #(
  parameter int NUM_REQS = 2,
  parameter int REQ_SELW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  output logic                grant_valid,
  output logic [REQ_SELW-1:0] grant_index,
  output logic [NUM_REQS-1:0] grant_onehot
);

  logic [REQ_SELW-1:0] ptr_q;
  logic [REQ_SELW-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = REQ_SELW'((int'(ptr_q) + k) % NUM_REQS);
      if (!grant_valid && requests[cand]) begin
        grant_valid = 1'b1;
        grant_index = cand;
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQS; i++)
      grant_onehot[i] = grant_valid && (grant_index == REQ_SELW'(i));
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr_q <= '0;
    else if (grant_valid)
      ptr_q <= (grant_index == REQ_SELW'(NUM_REQS-1)) ? '0 : grant_index + REQ_SELW'(1);
  end

endmodule

// File: rtl/vx_dvg_arb.sv
// Divergence-op arbiter: per-requester one-entry buffers, round-robin grant,
// registered split/join issue and per-warp busy tracking.
module vx_dvg_arb import vx_dvg_arb_pkg::*; #(
  parameter int NUM_REQS = 2,
  parameter int REQ_SELW = clog2_min1(NUM_REQS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0][NW_WIDTH-1:0]  req_wid,
  input  split_t [NUM_REQS-1:0]              req_split,
  input  join_t  [NUM_REQS-1:0]              req_sjoin,
  output logic [NUM_REQS-1:0]                req_ready,
  output logic                               sj_valid,
  output logic [NW_WIDTH-1:0]                sj_wid,
  output split_t                             sj_split,
  output join_t                              sj_sjoin,
  input  logic                               join_valid,
  input  logic [NW_WIDTH-1:0]                join_wid,
  output logic [NUM_WARPS-1:0]               warp_busy,
  output logic [31:0]                        perf_stalls
);

  dvg_req_t [NUM_REQS-1:0] buf_q;
  dvg_req_t [NUM_REQS-1:0] req_pkt;
  logic     [NUM_REQS-1:0] buf_valid;
  logic     [NUM_REQS-1:0] lower_hit;
  logic     [NUM_REQS-1:0] accept;
  logic     [NUM_REQS-1:0] grant_onehot;
  logic     [REQ_SELW-1:0] grant_idx;
  logic                    grant_valid;
  logic                    sj_is_join;
  logic [NUM_WARPS-1:0]    busy_q, set_mask, clr_mask;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .REQ_SELW (REQ_SELW)
  ) rr_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (buf_valid),
    .grant_valid  (grant_valid),
    .grant_index  (grant_idx),
    .grant_onehot (grant_onehot)
  );

  // Same-warp tie in one cycle: only the lowest-index requester may go.
  always_comb begin
    lower_hit = '0;
    for (int i = 0; i < NUM_REQS; i++)
      for (int j = 0; j < NUM_REQS; j++)
        if (j < i && req_valid[j] && req_wid[j] == req_wid[i])
          lower_hit[i] = 1'b1;
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
    assign req_ready[i] = (!buf_valid[i] || grant_onehot[i]) && !busy_q[req_wid[i]] && !lower_hit[i];
    assign accept[i]    = req_valid[i] && req_ready[i];
    assign req_pkt[i]   = '{wid: req_wid[i], is_join: req_sjoin[i].valid,
                            split: req_split[i], sjoin: req_sjoin[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= '0;
      buf_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_q[i]     <= req_pkt[i];
        end else if (grant_onehot[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sj_valid   <= 1'b0;
      sj_wid     <= '0;
      sj_split   <= '0;
      sj_sjoin   <= '0;
      sj_is_join <= 1'b0;
    end else begin
      sj_valid <= grant_valid;
      if (grant_valid) begin
        sj_wid     <= buf_q[grant_idx].wid;
        sj_split   <= buf_q[grant_idx].split;
        sj_sjoin   <= buf_q[grant_idx].sjoin;
        sj_is_join <= buf_q[grant_idx].is_join;
      end
    end
  end

  // A split is done once issued; a join waits for the unit's result.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_REQS; i++)
      if (accept[i]) set_mask[req_wid[i]] = 1'b1;
    if (sj_valid && !sj_is_join) clr_mask[sj_wid]   = 1'b1;
    if (join_valid)              clr_mask[join_wid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      perf_stalls <= '0;
    end else begin
      busy_q <= (busy_q | set_mask) & ~clr_mask;
      if (|(req_valid & ~req_ready))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end

  assign warp_busy = busy_q;

endmodule

// File: tb/tb_vx_dvg_arb.sv
// Bench for vx_dvg_arb: directed scenarios plus randomized traffic against a reference model.
module tb_vx_dvg_arb;
  import vx_dvg_arb_pkg::*;

  localparam int N = 2;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N-1:0]                req_valid;
  logic [N-1:0][NW_WIDTH-1:0]  req_wid;
  split_t [N-1:0]              req_split;
  join_t  [N-1:0]              req_sjoin;
  logic [N-1:0]                req_ready;
  logic                        sj_valid;
  logic [NW_WIDTH-1:0]         sj_wid;
  split_t                      sj_split;
  join_t                       sj_sjoin;
  logic                        join_valid;
  logic [NW_WIDTH-1:0]         join_wid;
  logic [NUM_WARPS-1:0]        warp_busy;
  logic [31:0]                 perf_stalls;

  int checks   = 0;
  int failures = 0;

  vx_dvg_arb #(.NUM_REQS(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wid(req_wid),
    .req_split(req_split), .req_sjoin(req_sjoin), .req_ready(req_ready),
    .sj_valid(sj_valid), .sj_wid(sj_wid), .sj_split(sj_split), .sj_sjoin(sj_sjoin),
    .join_valid(join_valid), .join_wid(join_wid), .warp_busy(warp_busy),
    .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  // Each valid request must carry exactly one payload kind.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (!reset && req_valid[i])
        assert (req_split[i].valid != req_sjoin[i].valid) else $error("illegal payload on req %0d", i);

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic split_t mk_split(input logic [31:0] pc);
    return '{valid: 1'b1, is_dvg: pc[0], then_tmask: pc[7:4], else_tmask: pc[11:8], next_pc: pc};
  endfunction

  task automatic idle();
    req_valid = '0; req_wid = '0; req_split = '0; req_sjoin = '0;
    join_valid = 1'b0; join_wid = '0;
  endtask

  task automatic set_req(input int i, input int wid, input bit is_join, input logic [31:0] pc);
    req_valid[i] = 1'b1;
    req_wid[i]   = NW_WIDTH'(wid);
    if (is_join) begin
      req_split[i] = '0;
      req_sjoin[i] = '{valid: 1'b1, stack_ptr: pc[DV_STACK_SIZEW-1:0]};
    end else begin
      req_split[i] = mk_split(pc);
      req_sjoin[i] = '0;
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 4;
    if (sj_valid !== 1'b0) begin failures++; $display("FAIL reset_sj_valid got=%0b want=0", sj_valid); end
    if (warp_busy !== '0) begin failures++; $display("FAIL reset_busy got=%0h want=0", warp_busy); end
    if (perf_stalls !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d want=0", perf_stalls); end
    if (req_ready !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b want=11", req_ready); end
    checks++;
    if (sj_wid !== '0 || sj_split !== '0 || sj_sjoin !== '0) begin
      failures++; $display("FAIL reset_payload got wid=%0d split=%0h join=%0h want 0", sj_wid, sj_split, sj_sjoin);
    end
    @(negedge clk);
  endtask

  task automatic test_single_split();
    do_reset();
    set_req(0, 3, 0, 32'h0000_0a5c);
    #1; checks++;
    if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL split_accept got=%0b want=1", req_ready[0]); end
    @(negedge clk); idle(); #1;   // t+1
    checks += 2;
    if (warp_busy[3] !== 1'b1) begin failures++; $display("FAIL split_busy_t1 got=%0b want=1", warp_busy[3]); end
    if (sj_valid !== 1'b0) begin failures++; $display("FAIL split_sjv_t1 got=%0b want=0", sj_valid); end
    @(negedge clk); #1;           // t+2
    checks += 4;
    if (sj_valid !== 1'b1) begin failures++; $display("FAIL split_sjv_t2 got=%0b want=1", sj_valid); end
    if (sj_wid !== 3'd3) begin failures++; $display("FAIL split_wid got=%0d want=3", sj_wid); end
    if (sj_split !== mk_split(32'h0000_0a5c)) begin failures++; $display("FAIL split_payload got=%0h want=%0h", sj_split, mk_split(32'h0000_0a5c)); end
    if (warp_busy[3] !== 1'b1) begin failures++; $display("FAIL split_busy_t2 got=%0b want=1", warp_busy[3]); end
    @(negedge clk); #1;           // t+3
    checks += 3;
    if (sj_valid !== 1'b0) begin failures++; $display("FAIL split_sjv_t3 got=%0b want=0", sj_valid); end
    if (warp_busy[3] !== 1'b0) begin failures++; $display("FAIL split_busy_t3 got=%0b want=0", warp_busy[3]); end
    if (sj_wid !== 3'd3) begin failures++; $display("FAIL split_wid_hold got=%0d want=3", sj_wid); end
    @(negedge clk);
  endtask

  task automatic test_join_round_trip();
    logic [31:0] p0;
    do_reset();
    set_req(1, 5, 1, 32'd2);
    #1; p0 = perf_stalls;
    checks++;
    if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL join_accept got=%0b want=1", req_ready[1]); end
    @(negedge clk); idle(); #1;   // t+1
    checks++;
    if (warp_busy[5] !== 1'b1) begin failures++; $display("FAIL join_busy_t1 got=%0b want=1", warp_busy[5]); end
    @(negedge clk);               // t+2
    set_req(0, 5, 0, 32'h44); #1;
    checks += 4;
    if (sj_valid !== 1'b1 || sj_wid !== 3'd5) begin failures++; $display("FAIL join_issue got v=%0b wid=%0d want v=1 wid=5", sj_valid, sj_wid); end
    if (sj_sjoin !== '{valid: 1'b1, stack_ptr: 2'd2}) begin failures++; $display("FAIL join_payload got=%0h want=6", sj_sjoin); end
    if (sj_split.valid !== 1'b0) begin failures++; $display("FAIL join_split_valid got=%0b want=0", sj_split.valid); end
    if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL join_block_same_warp got=%0b want=0", req_ready[0]); end
    @(negedge clk); idle();       // t+3
    join_valid = 1'b1; join_wid = 3'd5; #1;
    checks += 2;
    if (warp_busy[5] !== 1'b1) begin failures++; $display("FAIL join_busy_t3 got=%0b want=1", warp_busy[5]); end
    if (perf_stalls !== p0 + 32'd1) begin failures++; $display("FAIL join_perf got=%0d want=%0d", perf_stalls, p0 + 32'd1); end
    @(negedge clk); idle(); #1;   // t+4
    checks++;
    if (warp_busy[5] !== 1'b0) begin failures++; $display("FAIL join_busy_t4 got=%0b want=0", warp_busy[5]); end
    @(negedge clk);
  endtask

  task automatic test_same_warp_tie();
    do_reset();
    set_req(0, 2, 0, 32'd1);
    set_req(1, 2, 0, 32'd2);
    #1; checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL tie_ready got=%b want=01", req_ready); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); req_valid[0] = 1'b0; #1;
      checks++;
      if (req_ready[1] !== (c == 3)) begin failures++; $display("FAIL tie_ready_t%0d got=%0b want=%0b", c, req_ready[1], c == 3); end
    end
    @(negedge clk); idle(); #1;   // t+4
    checks++;
    if (perf_stalls !== 32'd3) begin failures++; $display("FAIL tie_perf got=%0d want=3", perf_stalls); end
    @(negedge clk); #1;           // t+5
    checks++;
    if (sj_valid !== 1'b1 || sj_wid !== 3'd2 || sj_split.next_pc !== 32'd2) begin
      failures++; $display("FAIL tie_second_issue got v=%0b wid=%0d pc=%0d want v=1 wid=2 pc=2", sj_valid, sj_wid, sj_split.next_pc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int nw[2];
    int q0[$];
    int q1[$];
    int exp_wid;
    do_reset();
    nw[0] = 0; nw[1] = 4;
    for (int c = 0; c < 16; c++) begin
      if (c < 14) begin
        set_req(0, nw[0], 0, 32'(c));
        set_req(1, nw[1], 0, 32'(c + 100));
      end else idle();
      #1;
      if (c >= 2 && c < 14) begin
        exp_wid = (c % 2 == 0) ? ((q0.size() > 0) ? q0.pop_front() : -1)
                               : ((q1.size() > 0) ? q1.pop_front() : -1);
        checks += 2;
        if (sj_valid !== 1'b1) begin failures++; $display("FAIL rr_valid c=%0d got=%0b want=1", c, sj_valid); end
        if (int'(sj_wid) !== exp_wid) begin failures++; $display("FAIL rr_order c=%0d got=%0d want=%0d", c, sj_wid, exp_wid); end
      end
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) begin
          if (i == 0) q0.push_back(nw[0]); else q1.push_back(nw[1]);
          nw[i] = (i * 4) + ((nw[i] + 1) % 4);
        end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_req(0, 1, 0, 32'd7);
    set_req(1, 6, 1, 32'd1);
    @(negedge clk); idle();       // t+1: grant req0, reload req0
    set_req(0, 2, 0, 32'd9);
    @(negedge clk); idle();       // t+2: both full, sj_valid high
    reset = 1'b1; #1;
    checks++;
    if (sj_valid !== 1'b1 || warp_busy === '0) begin failures++; $display("FAIL rst_setup got v=%0b busy=%0h want v=1 busy!=0", sj_valid, warp_busy); end
    @(negedge clk); reset = 1'b0; #1;
    checks += 4;
    if (sj_valid !== 1'b0) begin failures++; $display("FAIL rst_sjv got=%0b want=0", sj_valid); end
    if (warp_busy !== '0) begin failures++; $display("FAIL rst_busy got=%0h want=0", warp_busy); end
    if (sj_wid !== '0 || sj_split !== '0 || sj_sjoin !== '0) begin failures++; $display("FAIL rst_payload got wid=%0d split=%0h want 0", sj_wid, sj_split); end
    if (req_ready !== 2'b11) begin failures++; $display("FAIL rst_ready got=%b want=11", req_ready); end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (sj_valid !== 1'b0) begin failures++; $display("FAIL rst_discard got=%0b want=0", sj_valid); end
    @(negedge clk);
  endtask

  // Reference: buffers as a table, busy as a set of warps, pointer as an integer.
  task automatic test_random();
    dvg_req_t           mb[N];
    bit                 mb_v[N];
    bit [NUM_WARPS-1:0] m_busy;
    int                 m_ptr, g;
    bit                 m_sjv, pend_jv;
    dvg_req_t           m_sj;
    int unsigned        m_perf;
    int                 pend_jw;
    bit [N-1:0]         m_ready;
    bit [NUM_WARPS-1:0] setw, clrw;
    do_reset();
    for (int i = 0; i < N; i++) begin mb_v[i] = 0; mb[i] = '0; end
    m_busy = '0; m_ptr = 0; m_sjv = 0; m_sj = '0; m_perf = 0; pend_jv = 0; pend_jw = 0;
    for (int c = 0; c < 500; c++) begin
      idle();
      join_valid = pend_jv; join_wid = NW_WIDTH'(pend_jw);
      for (int i = 0; i < N; i++)
        if ($urandom_range(9) < 7)
          set_req(i, ($urandom_range(1) != 0) ? $urandom_range(3) : $urandom_range(7),
                  $urandom_range(1) != 0, $urandom());
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mb_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      for (int i = 0; i < N; i++) begin
        m_ready[i] = (!mb_v[i] || g == i) && !m_busy[req_wid[i]];
        for (int j = 0; j < i; j++)
          if (req_valid[j] && req_wid[j] == req_wid[i]) m_ready[i] = 0;
      end
      #1;
      checks += 6;
      if (req_ready !== m_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, m_ready); end
      if (sj_valid !== m_sjv) begin failures++; $display("FAIL rnd_sjv c=%0d got=%0b want=%0b", c, sj_valid, m_sjv); end
      if (sj_wid !== m_sj.wid) begin failures++; $display("FAIL rnd_wid c=%0d got=%0d want=%0d", c, sj_wid, m_sj.wid); end
      if (sj_split !== m_sj.split || sj_sjoin !== m_sj.sjoin) begin failures++; $display("FAIL rnd_payload c=%0d got=%0h/%0h want=%0h/%0h", c, sj_split, sj_sjoin, m_sj.split, m_sj.sjoin); end
      if (warp_busy !== m_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%0h want=%0h", c, warp_busy, m_busy); end
      if (perf_stalls !== m_perf) begin failures++; $display("FAIL rnd_perf c=%0d got=%0d want=%0d", c, perf_stalls, m_perf); end
      // advance the model across the clock edge
      setw = '0; clrw = '0;
      if (m_sjv && !m_sj.is_join) clrw[m_sj.wid] = 1;
      if (pend_jv) clrw[pend_jw] = 1;
      for (int i = 0; i < N; i++)
        if (req_valid[i] && !m_ready[i]) begin m_perf++; break; end
      pend_jv = m_sjv && m_sj.is_join;
      pend_jw = int'(m_sj.wid);
      m_sjv = (g >= 0);
      if (g >= 0) begin m_sj = mb[g]; mb_v[g] = 0; m_ptr = (g + 1) % N; end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && m_ready[i]) begin
          setw[req_wid[i]] = 1;
          mb_v[i] = 1;
          mb[i] = '{wid: req_wid[i], is_join: req_sjoin[i].valid, split: req_split[i], sjoin: req_sjoin[i]};
        end
      assert ((setw & clrw) == '0) else $error("busy set/clear collision c=%0d", c);
      m_busy = (m_busy | setw) & ~clrw;
      @(negedge clk);
    end
    idle();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_split();
    test_join_round_trip();
    test_same_warp_tie();
    test_round_robin();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_dvg_arb.md
# VX_dvg_arb

Divergence-op arbiter placed in front of the per-core split/join unit. It accepts split and join requests from `NUM_REQS` requesters, such as issue slots or SFU lanes, and buffers one request per requester. Each cycle it grants one request round-robin and drives it to the split/join unit through a registered output stage. It enforces one divergence operation in flight per warp and exports a per-warp busy mask that the warp scheduler uses to stall.

## Interface
Parameters:
- `NUM_REQS`, default 2: number of requesters; must be ≥1.
- `REQ_SELW`, default `` `CLOG2(NUM_REQS) ``: width of the grant index. Derived; do not override.

Ports:
- `clk`  in  1: core clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  `[NUM_REQS]`: request valid.
- `req_wid`  in  `[NUM_REQS][NW_WIDTH]`: warp id.
- `req_split`  in  `split_t[NUM_REQS]`: split payload.
- `req_sjoin`  in  `join_t[NUM_REQS]`: join payload.
- `req_ready`  out  `[NUM_REQS]`: request accepted this cycle when high together with `req_valid`.
- `sj_valid`  out  1: op to the split/join unit.
- `sj_wid`  out  `NW_WIDTH`: warp id of the op.
- `sj_split`  out  `split_t`: split payload of the op.
- `sj_sjoin`  out  `join_t`: join payload of the op.
- `join_valid`  in  1: registered join result from the split/join unit.
- `join_wid`  in  `NW_WIDTH`: warp id of the join result.
- `warp_busy`  out  `NUM_WARPS`: warp has a divergence op buffered or in flight.
- `perf_stalls`  out  32: count of cycles in which some requester is back-pressured.

## Operation
- **Payload.** Each request carries exactly one of `req_split.valid` or `req_sjoin.valid`. Both set, or neither set, is illegal; the bench asserts on it.
- **Per-requester buffer.** Each requester has a one-entry buffer: `valid`, `wid`, `is_join`, `split`, `sjoin`.
- **req_ready[i]** is high only when all three hold:
  - buffer i is empty, or buffer i is granted this cycle;
  - `warp_busy[req_wid[i]]` is 0;
  - no lower-index requester j has `req_valid[j]` asserted for the same wid this cycle (same-warp tie: lowest index wins).
- **Accept.** On `req_valid[i] && req_ready[i]`, load buffer i and set `busy[wid]` at the clock edge.
- **Grant.**
  - Round-robin over full buffers, one grant per cycle.
  - The priority pointer moves to the requester after the winner. It holds when there is no grant.
  - The granted buffer clears at the edge, unless it reloads in the same cycle.
- **Output register.** The granted entry is registered into `sj_*`. `sj_valid` is high for exactly one cycle per grant. Payload outputs hold their last value while `sj_valid` is 0. The unit has no backpressure, so a grant always completes.
- **Busy clear.**
  - Split: `busy[sj_wid]` clears at the edge that ends the cycle where `sj_valid && !is_join` (the stack push commits at that edge).
  - Join: `busy[join_wid]` clears at the edge that ends the cycle where `join_valid` is high.
  - Set and clear on the same warp in the same cycle cannot occur because accept requires busy=0. If it does occur, clear wins and the bench asserts on it.
- **`warp_busy`** equals the registered busy vector.
- **perf_stalls** increments in every cycle where any `req_valid[i] && !req_ready[i]`. It wraps at 2^32.

## Timing
- **Reset values:** all buffers empty; busy vector = 0; round-robin pointer = 0; `sj_valid` = 0; `sj_*` payload = 0; `perf_stalls` = 0. `req_ready` is a combinational function of the reset state.
- **Best-case latency:** accept in cycle t, grant in t+1, `sj_valid` in t+2, `join_valid` from the unit in t+3.
- **Busy clear timing:** for a split, busy is low in cycle t+3. For a join, busy is low in cycle t+4.
- **Same-warp issue interval:** the next accept for the same warp is possible at t+3 after a split and at t+4 after a join.
- **Throughput:** one grant per cycle across distinct warps.
- **Combinational paths:** `req_ready` depends on `req_valid` and `req_wid` of lower-index requesters.
- **Reset mid-operation** discards buffered and in-flight ops. Busy bits clear; the split/join unit is reset alongside.

## Structure
- Add `dvg_req_t` {wid, is_join, split_t split, join_t sjoin} to `VX_gpu_pkg`, next to `split_t` and `join_t`.
- Round-robin selection is instantiated from the existing `VX_rr_arbiter` sub-module; it is the only sub-module.
- Buffers, output register, busy vector and counter are local RTL.

## Test plan
- **Single split.** Single split on req0, wid=3, at t → `sj_valid` at t+2 with wid=3; `warp_busy[3]`=1 over t+1..t+2 and 0 at t+3.
- **Join round trip.** Join on req1, wid=5 → `sj_valid` at t+2; drive `join_valid`, wid=5, at t+3 → `warp_busy[5]` low at t+4. A second request for wid 5 at t+2 sees `req_ready`=0.
- **Same-warp tie.** req0 and req1 both wid=2 in the same cycle → only req0 accepted; req1 is accepted once busy clears; `perf_stalls` counts each blocked cycle.
- **Round-robin fairness.** Both requesters saturated with distinct warps → grants alternate 0,1,0,1; `sj_valid` is high every cycle after fill.
- **Mid-flight reset.** Reset asserted with both buffers full and `sj_valid` high → next cycle all outputs at their reset values and `warp_busy`=0.
